// File: rtl/control_sequencer_if.sv
// Instruction-fetch handshake between the control sequencer (master) and
// the instruction memory (slave).
interface control_sequencer_if #(
  parameter int PC_WIDTH = 8
);
  logic [PC_WIDTH-1:0] IMEM_ADDR;
  logic                IMEM_REQ;
  logic [7:0]          IMEM_DATA;
  logic                IMEM_VALID;

  modport master (
    output IMEM_ADDR,
    output IMEM_REQ,
    input  IMEM_DATA,
    input  IMEM_VALID
  );

  modport slave (
    input  IMEM_ADDR,
    input  IMEM_REQ,
    output IMEM_DATA,
    output IMEM_VALID
  );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/control FSM feeding the 4x8 register file, data
// memory and ALU operand select. One instruction in flight at a time.
module control_sequencer #(
  parameter int PC_WIDTH = 8,
  parameter int RESET_PC = 0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                RUN,
  control_sequencer_if.master imem,
  output logic [1:0]          REG_SOURCE,
  output logic [1:0]          REG_TWO,
  output logic [1:0]          REG_DEST,
  output logic                REGDST,
  output logic                REGWRITE,
  output logic                ALUSRC,
  output logic [7:0]          IMM,
  output logic                MEMREAD,
  output logic                MEMWRITE,
  output logic                MEMTOREG,
  output logic                RETIRE,
  output logic [2:0]          STATE
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  localparam logic [PC_WIDTH-1:0] RESET_PC_L = PC_WIDTH'(RESET_PC);

  state_t              r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [7:0]          r_ir;

  logic [1:0]          w_opcode;
  logic [PC_WIDTH-1:0] w_pc_inc;
  logic [PC_WIDTH-1:0] w_jump_off;
  state_t              w_after_retire;

  assign w_opcode       = r_ir[7:6];
  assign w_pc_inc       = r_pc + PC_WIDTH'(1);
  assign w_jump_off     = {{(PC_WIDTH-6){r_ir[5]}}, r_ir[5:0]};
  assign w_after_retire = RUN ? S_FETCH : S_IDLE;

  // State, program counter and instruction register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC_L;
      r_ir    <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (RUN) r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (imem.IMEM_VALID) begin
            r_ir    <= imem.IMEM_DATA;
            r_pc    <= w_pc_inc;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: r_state <= S_EXEC;
        S_EXEC: begin
          case (w_opcode)
            OP_ADD: r_state <= S_WB;
            OP_J: begin
              // r_pc already points past the jump, so the offset is relative to PC+1.
              r_pc    <= r_pc + w_jump_off;
              r_state <= w_after_retire;
            end
            default: r_state <= S_MEM;
          endcase
        end
        S_MEM: begin
          if (w_opcode == OP_LW) r_state <= S_WB;
          else                   r_state <= w_after_retire;
        end
        S_WB:    r_state <= w_after_retire;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Moore output decode of state and IR; reset clears both so strobes drop at once.
  always_comb begin
    REGDST   = 1'b0;
    REGWRITE = 1'b0;
    ALUSRC   = 1'b0;
    MEMREAD  = 1'b0;
    MEMWRITE = 1'b0;
    MEMTOREG = 1'b0;
    RETIRE   = 1'b0;
    imem.IMEM_REQ = 1'b0;
    case (r_state)
      S_FETCH: imem.IMEM_REQ = 1'b1;
      S_EXEC: begin
        if (w_opcode == OP_LW || w_opcode == OP_SW) ALUSRC = 1'b1;
        else                                        ALUSRC = 1'b0;
        if (w_opcode == OP_J) RETIRE = 1'b1;
        else                  RETIRE = 1'b0;
      end
      S_MEM: begin
        ALUSRC = 1'b1;
        if (w_opcode == OP_LW) begin
          MEMREAD  = 1'b1;
          MEMTOREG = 1'b1;
        end else begin
          MEMWRITE = 1'b1;
          RETIRE   = 1'b1;
        end
      end
      S_WB: begin
        REGWRITE = 1'b1;
        RETIRE   = 1'b1;
        if (w_opcode == OP_LW) begin
          MEMTOREG = 1'b1;
          REGDST   = 1'b0;
        end else begin
          MEMTOREG = 1'b0;
          REGDST   = 1'b1;
        end
      end
      default: begin
        REGWRITE = 1'b0;
      end
    endcase
  end

  assign imem.IMEM_ADDR = r_pc;
  assign REG_SOURCE     = r_ir[5:4];
  assign REG_TWO        = r_ir[3:2];
  assign REG_DEST       = r_ir[1:0];
  assign IMM            = {{6{r_ir[1]}}, r_ir[1:0]};
  assign STATE          = r_state;

endmodule
